// File: rtl/fir4_rr_scheduler_if.sv
// Bus between per-channel sample sources / downstream consumer and the
// fir4_rr_scheduler engine.
interface fir4_rr_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 3
);
  logic [NUM_CH-1:0]    in_valid;
  logic [16*NUM_CH-1:0] in_data;
  logic [NUM_CH-1:0]    in_ready;
  logic [NUM_CH-1:0]    ch_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [19:0]          out_data;
  logic [CH_W-1:0]      out_ch;

  // Sources/consumer side.
  modport master (
    output in_valid, in_data, ch_clear, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  // Engine side.
  modport slave (
    input  in_valid, in_data, ch_clear, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/fir4_rr_scheduler.sv
// Time-multiplexed 4-tap FIR (weights 1,2,3,4) shared by NUM_CH channels.
// A round-robin arbiter grants one ready channel per cycle; the result is
// registered with its channel tag behind a valid/ready output.
module fir4_rr_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fir4_rr_scheduler_if.slave   bus
);

  localparam int unsigned N = NUM_CH;

  logic [15:0]     hist_q [NUM_CH][4];
  logic [15:0]     hist_d [NUM_CH][4];
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [19:0]     out_data_q, out_data_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;

  logic            found;
  logic [CH_W-1:0] grant;
  logic            slot_free;
  logic            accept;
  logic [19:0]     result;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    grant = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      for (int unsigned c = 0; c < N; c++) begin
        if (!found && (c == idx) && bus.in_valid[c]) begin
          found = 1'b1;
          grant = CH_W'(c);
        end
      end
    end
  end

  // Handshake: the slot is free when empty or being drained this cycle.
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    accept    = found && slot_free && !rst;
    for (int unsigned c = 0; c < N; c++) begin
      bus.in_ready[c] = accept && (CH_W'(c) == grant);
    end
  end

  // History update and tap-weighted sum; clear is applied before the shift
  // so a same-cycle clear+accept filters against an all-zero history.
  always_comb begin
    hist_d = hist_q;
    result = '0;
    for (int unsigned c = 0; c < N; c++) begin
      if (bus.ch_clear[c]) begin
        for (int unsigned k = 0; k < 4; k++) hist_d[c][k] = '0;
      end
      if (accept && (CH_W'(c) == grant)) begin
        hist_d[c][3] = hist_d[c][2];
        hist_d[c][2] = hist_d[c][1];
        hist_d[c][1] = hist_d[c][0];
        hist_d[c][0] = bus.in_data[16*c +: 16];
        result = 20'(hist_d[c][0])
               + 20'(hist_d[c][1]) * 20'd2
               + 20'(hist_d[c][2]) * 20'd3
               + 20'(hist_d[c][3]) * 20'd4;
      end
    end
  end

  // Output register and arbitration pointer next-state.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (accept) begin
      ptr_d       = grant;
      out_valid_d = 1'b1;
      out_data_d  = result;
      out_ch_d    = grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < N; c++) begin
        for (int unsigned k = 0; k < 4; k++) hist_q[c][k] <= '0;
      end
      ptr_q       <= CH_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      hist_q      <= hist_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_fir4_rr_scheduler.sv
// Self-checking bench for fir4_rr_scheduler: directed scenarios plus random
// traffic, all compared against a behavioural model of the filter/arbiter.
module tb_fir4_rr_scheduler;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 3;
  localparam int DW     = 16 * NUM_CH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir4_rr_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();
  fir4_rr_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: sample histories, last-grant pointer, output register.
  int unsigned m_hist [NUM_CH][4];
  int unsigned m_ptr;
  bit          m_valid;
  int unsigned m_data;
  int unsigned m_ch;

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 4; k++) m_hist[c][k] = 0;
    m_ptr = NUM_CH - 1; m_valid = 0; m_data = 0; m_ch = 0;
  endtask

  function automatic int unsigned m_grant(input logic [NUM_CH-1:0] v, output bit fnd);
    fnd = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      int unsigned c;
      c = (m_ptr + i) % NUM_CH;
      if (v[c]) begin fnd = 1; return c; end
    end
    return 0;
  endfunction

  task automatic m_update(input logic [NUM_CH-1:0] v, input logic [DW-1:0] d,
                          input logic [NUM_CH-1:0] clr, input logic ordy, input logic r);
    bit fnd, acc;
    int unsigned g;
    if (r) begin
      m_reset();
      return;
    end
    g   = m_grant(v, fnd);
    acc = fnd && (!m_valid || ordy);
    for (int c = 0; c < NUM_CH; c++)
      if (clr[c]) for (int k = 0; k < 4; k++) m_hist[c][k] = 0;
    if (acc) begin
      for (int k = 3; k > 0; k--) m_hist[g][k] = m_hist[g][k-1];
      m_hist[g][0] = d[16*g +: 16];
      m_data = 0;
      for (int k = 0; k < 4; k++) m_data += (k + 1) * m_hist[g][k];
      m_valid = 1; m_ch = g; m_ptr = g;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
  endtask

  // One clock: drive at negedge, check against model, advance model at posedge.
  task automatic step(input logic [NUM_CH-1:0] v, input logic [DW-1:0] d,
                      input logic [NUM_CH-1:0] clr, input logic ordy, input logic r);
    bit fnd;
    int unsigned g, exp_rdy;
    @(negedge clk);
    bus.in_valid = v; bus.in_data = d; bus.ch_clear = clr; bus.out_ready = ordy; rst = r;
    #1;
    g = m_grant(v, fnd);
    exp_rdy = (fnd && (!m_valid || ordy) && !r) ? (32'd1 << g) : 0;
    check("in_ready",  bus.in_ready,  exp_rdy);
    check("out_valid", bus.out_valid, m_valid);
    check("out_data",  bus.out_data,  m_data);
    check("out_ch",    bus.out_ch,    m_ch);
    @(posedge clk);
    m_update(v, d, clr, ordy, r);
    #1;
  endtask

  function automatic logic [DW-1:0] put(input int ch, input logic [15:0] val);
    logic [DW-1:0] x;
    x = '0;
    x[16*ch +: 16] = val;
    return x;
  endfunction

  function automatic logic [DW-1:0] all_lanes(input logic [15:0] val);
    logic [DW-1:0] x;
    for (int c = 0; c < NUM_CH; c++) x[16*c +: 16] = val;
    return x;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] x;
    for (int c = 0; c < NUM_CH; c++)
      x[16*c +: 16] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    return x;
  endfunction

  int unsigned imp_exp [5] = '{1, 2, 3, 4, 0};
  int unsigned clr_seq [3] = '{10, 20, 30};

  initial begin
    rst = 1'b1;
    bus.in_valid = '0; bus.in_data = '0; bus.ch_clear = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_ch",    bus.out_ch,    0);
    check("rst_in_ready",  bus.in_ready,  0);

    // Impulse response on channel 0.
    for (int i = 0; i < 5; i++) begin
      step(4'b0001, put(0, (i == 0) ? 16'd1 : 16'd0), '0, 1'b1, 1'b0);
      check("imp_data", bus.out_data, imp_exp[i]);
      check("imp_ch",   bus.out_ch,   0);
    end

    // Full-scale samples on channel 2.
    for (int i = 0; i < 4; i++) step(4'b0100, put(2, 16'hFFFF), '0, 1'b1, 1'b0);
    check("max_data", bus.out_data, 655350);
    check("max_ch",   bus.out_ch,   2);

    // Clear coincident with accept on channel 1.
    for (int i = 0; i < 3; i++) step(4'b0010, put(1, 16'(clr_seq[i])), '0, 1'b1, 1'b0);
    step(4'b0010, put(1, 16'd7), 4'b0010, 1'b1, 1'b0);
    check("clr_data", bus.out_data, 7);
    step(4'b0010, put(1, 16'd0), '0, 1'b1, 1'b0);
    check("clr_next", bus.out_data, 14);

    // Backpressure: result held while consumer stalls, accept on release.
    step(4'b1000, put(3, 16'd100), '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, all_lanes(16'd9), '0, 1'b0, 1'b0);
      check("bp_valid", bus.out_valid, 1);
      check("bp_data",  bus.out_data,  100);
      check("bp_ch",    bus.out_ch,    3);
    end
    step(4'b1111, all_lanes(16'd9), '0, 1'b1, 1'b0);
    check("rel_ch",   bus.out_ch,   0);
    check("rel_data", bus.out_data, 9);

    // Reset while a result is stalled.
    step('0, '0, '0, 1'b0, 1'b0);
    step('0, '0, '0, 1'b0, 1'b1);
    check("rs_valid", bus.out_valid, 0);
    check("rs_data",  bus.out_data,  0);
    check("rs_ready", bus.in_ready,  0);

    // Round-robin under continuous demand, first sample 5 from channel 0.
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, (i == 0) ? all_lanes(16'd5) : rnd_data(), '0, 1'b1, 1'b0);
      check("rr_ch", bus.out_ch, i % NUM_CH);
      if (i == 0) check("rr_first", bus.out_data, 5);
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(NUM_CH'($urandom), rnd_data(),
           ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0,
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fir4_rr_scheduler.md
# fir4_rr_scheduler

Time-multiplexed 4-tap FIR engine: one shared tap-weighted-sum datapath serves NUM_CH independent 16-bit sample streams. Each channel keeps its own 4-deep sample history. A round-robin arbiter picks one ready channel per cycle, shifts its sample into that channel's history and computes y = 1·h0 + 2·h1 + 3·h2 + 4·h3. The result is registered with its channel tag behind a valid/ready output port. The block sits between per-channel sample sources and a single downstream consumer.

## Interface
- NUM_CH, 4: number of channels, 2..8.
- CH_W, 3: channel-tag width; must satisfy 2^CH_W ≥ NUM_CH.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  NUM_CH  per-channel sample valid.
- in_data  in  16·NUM_CH  channel c sample on bits [16c+15:16c], unsigned.
- in_ready  out  NUM_CH  one-hot or zero; sample accepted where in_valid & in_ready.
- ch_clear  in  NUM_CH  per-channel history clear, sampled every cycle.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result when out_valid & out_ready.
- out_data  out  20  filter result, unsigned.
- out_ch  out  CH_W  channel that produced out_data.

## Operation
- **History:** per channel, h0 (newest) to h3 (oldest), 16 bits each. On accept for channel c: h3←h2, h2←h1, h1←h0, h0←in_data[c].
- **Arithmetic:**
  - Result uses the post-shift history: 1·new + 2·old_h0 + 3·old_h1 + 4·old_h2.
  - All terms are unsigned and zero-extended to 20 bits.
  - The maximum is 10·65535 = 655350, so there is no overflow and no truncation.
- **Slot free:** out_valid==0, or out_valid & out_ready in the same cycle.
- **Arbitration:**
  - Pointer ptr holds the last granted channel.
  - Candidate order is ptr+1, ptr+2, … modulo NUM_CH.
  - The grant goes to the first channel with in_valid set.
  - in_ready[grant] = slot free. All other in_ready bits are 0.
  - in_ready is 0 whenever no in_valid is set or the slot is not free.
  - ptr updates to the granted channel only on an accept.
  - in_ready combinationally depends on in_valid. Sources must not make in_valid depend on in_ready.
- **Output register:**
  - On accept: out_data←result, out_ch←c, out_valid←1.
  - Else, if out_valid & out_ready: out_valid←0. out_data and out_ch hold their last values.
  - While out_valid & !out_ready: out_data and out_ch are stable and no accepts occur.
- **ch_clear[c]:**
  - Zeroes all four history entries of channel c at the edge.
  - If channel c is accepted in the same cycle, the cleared history is used for both the shift and the result. Outcome: h0=new, h1..h3=0, out_data=new.
  - ch_clear does not affect the output register, ptr or a pending result.
- **Reset:**
  - All histories = 0, ptr = NUM_CH−1 (channel 0 is first priority).
  - out_valid=0, out_data=0, out_ch=0, in_ready=0.
  - A result pending when rst asserts is discarded.
  - Reset overrides accept and clear in the same cycle.

## Timing
- Accept in cycle N puts the result on out_* in cycle N+1 with out_valid=1. Latency is 1 cycle.
- Throughput is one sample per cycle aggregate when out_ready is held high. Back-to-back accepts are allowed because the slot frees in the same cycle.
- Fairness: under continuous demand, each requesting channel is granted at least once every NUM_CH accepts.
- out_valid may fall only after a handshake or rst.
- A result always corresponds to exactly one accepted sample; no result is duplicated or dropped.

## Test plan
- **Impulse response:** channel 0 accepts samples 1, 0, 0, 0, 0 with out_ready=1. Required out_data: 1, 2, 3, 4, 0, all with out_ch=0. All other channels idle.
- **Round-robin:** all four in_valid held high with out_ready=1. Required out_ch sequence: 0, 1, 2, 3, 0, 1 … and exactly one in_ready bit high per cycle.
- **Backpressure:**
  - Hold out_ready=0 after the first result: out_valid stays 1, out_data and out_ch stay frozen, in_ready=0 for 5 cycles.
  - Release out_ready: the next accept occurs in the same cycle as the release.
- **Max value:** 4 accepts of 65535 on channel 2. Required final out_data = 655350 (0x9FFF6) and out_ch=2.
- **Clear with accept:**
  - Channel 1 history is 10, 20, 30. Assert ch_clear[1] in the cycle that accepts 7. Required out_data=7.
  - The next accept of 0 gives out_data=14.
- **Reset mid-stall:** pending out_valid=1 with out_ready=0, then assert rst for 1 cycle.
  - Next cycle: out_valid=0, out_data=0, in_ready=0.
  - After release, channel 0 wins first when all channels request, and the first sample 5 gives out_data=5.
